// File: rtl/to_montgomery_32bit.sv
// ---------------------------------------------------------------------------
// to_montgomery_32bit
//
// Converts a signed 32-bit coefficient into the Montgomery domain used by the
// Dilithium NTT datapath: t = a * 2^32 mod q, with q = 8380417.
// The value is multiplied by R2 = 2^64 mod q, and one Montgomery reduction
// then divides by 2^32. That leaves a * 2^32 (mod q).
//
// Ports:
//   clock  in   1   system clock, rising edge
//   reset  in   1   synchronous active-low reset
//   start  in   1   conversion request, sampled only while idle
//   a      in   32  signed input coefficient, |a| < 2^31
//   busy   out  1   high from the cycle after accept until done
//   done   out  1   one-cycle completion pulse
//   t      out  32  signed result, held until the next completion
// ---------------------------------------------------------------------------
module to_montgomery_32bit #(
    parameter logic signed [31:0] Q         = 32'sd8380417,
    parameter logic signed [31:0] QINV      = 32'sd58728449,
    parameter logic signed [31:0] R2        = 32'sd2365951,
    parameter bit                 CANONICAL = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    output logic        busy,
    output logic        done,
    output logic [31:0] t
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        RED1 = 3'd2,
        RED2 = 3'd3,
        FIX  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic signed [31:0] a_q, a_d;
    logic signed [63:0] p_q, p_d;
    logic signed [31:0] m_q, m_d;
    logic signed [31:0] traw_q, traw_d;
    logic        [31:0] t_q, t_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    // Datapath operands. Everything is sign-extended to 64 bits so that the
    // products keep their sign.
    logic signed [63:0] a_ext_s;
    logic signed [63:0] r2_ext_s;
    logic signed [63:0] m_ext_s;
    logic signed [63:0] q_ext_s;
    logic signed [63:0] prod_s;
    logic        [31:0] m_prod_s;
    logic signed [63:0] mq_s;
    logic signed [63:0] diff_s;
    logic        [31:0] unused_low_s;

    assign a_ext_s  = {{32{a_q[31]}}, a_q};
    assign r2_ext_s = {{32{R2[31]}}, R2};
    assign m_ext_s  = {{32{m_q[31]}}, m_q};
    assign q_ext_s  = {{32{Q[31]}}, Q};
    assign prod_s   = a_ext_s * r2_ext_s;

    // Only the low word matters: m = p * q^-1 mod 2^32.
    // The product wraps on purpose.
    assign m_prod_s = p_q[31:0] * QINV;

    assign mq_s     = m_ext_s * q_ext_s;

    // m*q matches p in the low 32 bits, so the difference is an exact
    // multiple of 2^32. Its upper word is the arithmetic shift by 32.
    assign diff_s       = p_q - mq_s;
    assign unused_low_s = diff_s[31:0];

    // Next-state and datapath control for the five-step conversion.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        p_d     = p_q;
        m_d     = m_q;
        traw_d  = traw_q;
        t_d     = t_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (start == 1'b1) begin
                    a_d     = a;
                    busy_d  = 1'b1;
                    state_d = MUL;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                p_d     = prod_s;
                state_d = RED1;
            end
            RED1: begin
                m_d     = m_prod_s;
                state_d = RED2;
            end
            RED2: begin
                traw_d  = diff_s[63:32];
                state_d = FIX;
            end
            FIX: begin
                // traw lies in (-q, q). One conditional add of q makes it
                // canonical.
                if (CANONICAL && traw_q[31]) begin
                    t_d = traw_q + Q;
                end else begin
                    t_d = traw_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (reset == 1'b0) begin
            state_q <= IDLE;
            a_q     <= 32'sd0;
            p_q     <= 64'sd0;
            m_q     <= 32'sd0;
            traw_q  <= 32'sd0;
            t_q     <= 32'd0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            p_q     <= p_d;
            m_q     <= m_d;
            traw_q  <= traw_d;
            t_q     <= t_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign t    = t_q;

endmodule

// File: tb/tb_to_montgomery_32bit.sv
module tb_to_montgomery_32bit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        start1;
    logic [31:0] a;
    logic        busy, done, busy1, done1;
    logic [31:0] t, t1;

    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    to_montgomery_32bit #(.CANONICAL(1'b1)) dut (
        .clock(clock), .reset(reset), .start(start), .a(a),
        .busy(busy), .done(done), .t(t)
    );

    to_montgomery_32bit #(.CANONICAL(1'b0)) dut_c0 (
        .clock(clock), .reset(reset), .start(start1), .a(a),
        .busy(busy1), .done(done1), .t(t1)
    );

    // Reference model: a * 2^32 mod q, canonical in [0, q).
    function automatic logic [31:0] ref_mont(input logic [31:0] av);
        longint v;
        v = (longint'($signed(av)) * 64'sd4294967296) % 64'sd8380417;
        if (v < 0) v = v + 64'sd8380417;
        return v[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [31:0] ev;
        if (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            chk(tag, {32'd0, t}, {32'd0, ev});
        end else begin
            chk("scoreboard_underflow", 64'd0, 64'd1);
        end
    endtask

    // Single start pulse; checks latency, busy, done width and result.
    task automatic run_one(input string tag, input logic [31:0] av);
        int n;
        @(negedge clock);
        chk("done_idle_low", {63'd0, done}, 64'd0);
        start = 1'b1;
        a     = av;
        exp_q.push_back(ref_mont(av));
        @(negedge clock);
        start = 1'b0;
        a     = $urandom;
        chk("busy_after_accept", {63'd0, busy}, 64'd1);
        n = 0;
        while (done !== 1'b1 && n < 12) begin
            @(negedge clock);
            n++;
        end
        chk("latency", 64'(n), 64'd4);
        chk("done", {63'd0, done}, 64'd1);
        chk("busy_at_done", {63'd0, busy}, 64'd0);
        pop_chk(tag);
    endtask

    // start held high: one conversion every 5 cycles.
    task automatic stream(input string tag, input int cnt, input bit rnd);
        logic [31:0] v;
        @(negedge clock);
        start = 1'b1;
        for (int i = 0; i < cnt; i++) begin
            if (rnd) begin
                v = $urandom;
                if (v == 32'h8000_0000) v = 32'd0;
            end else begin
                v = 32'(i + 1);
            end
            a = v;
            exp_q.push_back(ref_mont(v));
            repeat (4) @(negedge clock);
            chk("stream_gap", {63'd0, done}, 64'd0);
            @(negedge clock);
            chk("stream_done", {63'd0, done}, 64'd1);
            pop_chk(tag);
        end
        start = 1'b0;
    endtask

    initial begin
        int  n;
        bit  seen;
        int  ndone;
        logic signed [31:0] t1s;

        reset  = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        a      = 32'd0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("reset_idle", {30'd0, done, busy, t}, 64'd0);
        end

        // Basic and boundary values.
        run_one("a=1", 32'd1);
        chk("a=1_const", {32'd0, t}, 64'd4193792);
        run_one("a=0", 32'd0);
        run_one("a=2", 32'd2);
        chk("a=2_const", {32'd0, t}, 64'd7167);
        run_one("a=-1", 32'hFFFF_FFFF);
        chk("a=-1_const", {32'd0, t}, 64'd4186625);
        run_one("a=q-1", 32'd8380416);
        chk("a=q-1_const", {32'd0, t}, 64'd4186625);
        run_one("a=q", 32'd8380417);
        chk("a=q_const", {32'd0, t}, 64'd0);
        run_one("a=-(2^31-1)", 32'h8000_0001);

        // Centred-range instance.
        @(negedge clock);
        start1 = 1'b1;
        a      = 32'd1;
        @(negedge clock);
        start1 = 1'b0;
        n = 0;
        while (done1 !== 1'b1 && n < 12) begin
            @(negedge clock);
            n++;
        end
        chk("c0_latency", 64'(n), 64'd4);
        t1s = t1;
        chk("c0_value", {63'd0, (t1s == 32'sd4193792 || t1s == -32'sd4186625)}, 64'd1);

        // Second start during MUL is ignored.
        @(negedge clock);
        start = 1'b1;
        a     = 32'd1;
        exp_q.push_back(ref_mont(32'd1));
        @(negedge clock);
        a = 32'd5;
        @(negedge clock);
        start = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 4) begin
                chk("ignore_done_at_4", {63'd0, done}, 64'd1);
                pop_chk("ignore_t");
            end
            if (done === 1'b1) ndone++;
            @(negedge clock);
        end
        chk("ignore_one_done", 64'(ndone), 64'd1);

        // Back-to-back with start held high: 1, 2, 3.
        stream("stream123", 3, 1'b0);
        chk("stream_a2", {32'd0, ref_mont(32'd2)}, 64'd7167);

        // Reset during RED1 aborts the operation.
        @(negedge clock);
        start = 1'b1;
        a     = 32'd7;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clock);
            if (done === 1'b1) seen = 1'b1;
        end
        chk("abort_no_done", {63'd0, seen}, 64'd0);
        chk("abort_t_zero", {32'd0, t}, 64'd0);
        chk("abort_busy_low", {63'd0, busy}, 64'd0);
        run_one("after_abort_a=1", 32'd1);

        // Random regression.
        stream("random", 10000, 1'b1);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/to_montgomery_32bit.md
Name: to_montgomery_32bit

Overview:
Converts a signed 32-bit coefficient from the normal domain into the Montgomery domain used by the Dilithium NTT datapath. It computes t = a·2^32 mod q with q = 8380417. Internally it multiplies by R2 = 2^64 mod q and then applies one Montgomery reduction. It sits in front of the NTT/pointwise-multiply units, and its output feeds the 32-bit Montgomery reduction block's operands.

Parameters:
Q, 8380417, Dilithium modulus.
QINV, 58728449, q^-1 mod 2^32.
R2, 2365951, 2^64 mod q.
CANONICAL, 1, 1 = output in [0, q); 0 = output in centred range (-q, q).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-low reset (reset == 0 resets on the clock edge).
start  input  1  request; sampled only in IDLE.
a  input  32 signed  input coefficient; any value with |a| < 2^31 is legal.
busy  output  1  high from the cycle after start is accepted until done is asserted.
done  output  1  one-cycle completion pulse.
t  output  32 signed  result; valid when done = 1, held until the next completion.

Behaviour:
- Reset (reset == 0 at an edge):
  - state <= IDLE; done, busy and t <= 0.
  - All internal registers (a_reg, p, m, t_raw) <= 0.
  - Reset has priority over every other action.
- States: IDLE -> MUL -> RED1 -> RED2 -> FIX -> IDLE. All transitions are unconditional except IDLE.
- IDLE:
  - If start == 1: a_reg <= a, busy <= 1, go to MUL.
  - Otherwise stay in IDLE.
  - done <= 0 in IDLE, except on the FIX->IDLE transition edge.
- MUL: p <= a_reg * R2. This is a 64-bit signed product; |p| < 2^31·q, so the Montgomery bound holds.
- RED1: m <= low 32 bits of (p[31:0] * QINV). m is interpreted as signed 32-bit and wraps mod 2^32.
- RED2: t_raw <= (p - m*Q) >>> 32. The shift is arithmetic. The low 32 bits of the difference are zero by construction. t_raw lies in (-q, q).
- FIX:
  - If CANONICAL = 1: t <= t_raw + Q when t_raw < 0, else t <= t_raw.
  - If CANONICAL = 0: t <= t_raw.
  - On the same edge: done <= 1, busy <= 0, go to IDLE.
- Latency: start accepted at edge k gives done = 1 during the cycle after edge k+4. That is 4 clocks from accept to done; throughput is one conversion per 5 cycles.
- done stays high for exactly one cycle. The next edge clears it unless a new completion occurs on that edge.
- t holds its last result until the next FIX. It is never cleared by an idle cycle, only by reset.
- start while busy (states MUL..FIX) is ignored. It is not queued, and a is not resampled.
- start high in the cycle where done = 1: state is IDLE, so the request is accepted. This gives back-to-back operation.
- a may change after acceptance without effect, because it is captured in a_reg.
- reset asserted mid-operation: the operation is aborted, no done is produced, and t = 0.
- Arithmetic: all multiplies are signed; constants are sign-extended 32-bit signed. There is no saturation; wrap only occurs in m, as specified.
- Identity: with CANONICAL = 1, t ≡ a·2^32 (mod q) and 0 ≤ t < q for every legal a.

Test Plan:
- Reset/idle: reset = 0 for 2 cycles, then reset = 1 with start = 0 for 10 cycles -> done = 0, busy = 0, t = 0 throughout.
- Basic values (CANONICAL = 1), each a single start pulse:
  - a = 1 -> t = 4193792.
  - a = 0 -> t = 0.
  - a = 2 -> t = 7167.
  - In each case done pulses exactly 4 clocks after the accept edge.
- Negative and boundary inputs:
  - a = -1 -> t = 4186625.
  - a = 8380416 -> t = 4186625.
  - a = 8380417 -> t = 0.
  - a = -2147483647 -> t equals the software model (a·2^32 mod q, in [0, q)).
- CANONICAL = 0: a = 1 -> t is 4193792 or -4186625 and lies in (-q, q).
- Handshake:
  - Second start pulse during MUL with a = 5 -> ignored; one done only, t for the first a.
  - start held high continuously with a sequence 1, 2, 3 -> done every 5 cycles; t = 4193792, 7167, then the matching model value.
- Reset during RED1 -> no done, t = 0, busy = 0. A fresh start with a = 1 afterwards -> t = 4193792 after normal latency.
- Random regression: 10,000 random 32-bit a with |a| < 2^31 -> t matches the reference model (a·2^32 mod q, canonical) on every done.
